// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Buffered UART transmitter. A byte FIFO with a valid/ready write port feeds
//   an 8N1 serializer (LSB first, idle high). Upstream logic can push bytes
//   without waiting for the frame in flight to finish.
//
//   Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
//   between the last data bit and the stop bit (11-bit frame). With the macro
//   undefined the frame is strict 8N1 and no parity logic exists.
//
// Parameters
//   CLOCK_FREQUENCY  i_clk frequency in Hz
//   BAUD_RATE        line rate in bit/s (CLOCK_FREQUENCY/BAUD_RATE must be >= 2)
//   FIFO_DEPTH       byte entries, power of 2, >= 2
//
// Ports
//   i_clk         system clock, rising edge
//   i_rst         asynchronous active-high reset
//   i_wr_valid    write request
//   i_wr_byte     byte to enqueue
//   o_wr_ready    FIFO can accept (count < FIFO_DEPTH)
//   o_fifo_count  bytes held in the FIFO (excludes the byte being sent)
//   o_tx_serial   registered serial line
//   o_tx_active   high from start bit through stop bit
//   o_tx_done     one-cycle pulse during the last stop-bit cycle
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int CLOCK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE       = 9600,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_wr_valid,
  input  logic [7:0]                    i_wr_byte,
  output logic                          o_wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_tx_serial,
  output logic                          o_tx_active,
  output logic                          o_tx_done
);

  localparam int CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int CW           = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  // o_tx_done is registered, so it is scheduled one cycle ahead of the
  // last stop-bit cycle.
  localparam logic [CW-1:0] BAUD_DONE = CW'(CLKS_PER_BIT - 2);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  // FIFO storage and bookkeeping
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  // Serializer state
  state_t        r_state;
  logic [CW-1:0] r_baud_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_tx_serial;
  logic          r_tx_active;
  logic          r_tx_done;

  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_baud_last;

  // Ready depends on count only: a pop in the same cycle does not make room
  // for a write while full.
  assign w_full      = (r_count == CNT_FULL);
  assign w_push      = i_wr_valid && !w_full;
  assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
  assign w_baud_last = (r_baud_cnt == BAUD_LAST);

  assign o_wr_ready   = !w_full;
  assign o_fifo_count = r_count;
  assign o_tx_serial  = r_tx_serial;
  assign o_tx_active  = r_tx_active;
  assign o_tx_done    = r_tx_done;

  // Storage array has no reset so it can map onto RAM; its contents are
  // meaningless after reset because the pointers and count are cleared.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_byte;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_ONE;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_ONE;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_baud_cnt  <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_tx_serial <= 1'b1;
      r_tx_active <= 1'b0;
      r_tx_done   <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx_serial <= 1'b1;
          r_baud_cnt  <= '0;
          r_bit_idx   <= '0;
          if (w_pop) begin
            // The start bit goes out on the same edge as the pop.
            r_shift     <= r_mem[r_rd_ptr];
            r_tx_serial <= 1'b0;
            r_tx_active <= 1'b1;
            r_state     <= S_START;
          end
        end

        S_START: begin
          if (w_baud_last) begin
            r_baud_cnt  <= '0;
            r_tx_serial <= r_shift[0];
            r_state     <= S_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + BAUD_ONE;
          end
        end

        S_DATA: begin
          if (w_baud_last) begin
            r_baud_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_tx_serial <= ^r_shift;
              r_state     <= S_PARITY;
`else
              r_tx_serial <= 1'b1;
              r_state     <= S_STOP;
`endif
            end else begin
              r_bit_idx   <= r_bit_idx + 3'd1;
              r_tx_serial <= r_shift[r_bit_idx + 3'd1];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + BAUD_ONE;
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_baud_last) begin
            r_baud_cnt  <= '0;
            r_tx_serial <= 1'b1;
            r_state     <= S_STOP;
          end else begin
            r_baud_cnt <= r_baud_cnt + BAUD_ONE;
          end
        end
`endif

        S_STOP: begin
          if (r_baud_cnt == BAUD_DONE) begin
            r_tx_done <= 1'b1;
          end
          if (w_baud_last) begin
            r_baud_cnt  <= '0;
            r_tx_active <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_baud_cnt <= r_baud_cnt + BAUD_ONE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_tx_serial <= 1'b1;
          r_tx_active <= 1'b0;
          r_baud_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Directed testbench for uart_tx_fifo with CLKS_PER_BIT = 10. Expected bytes
//   are queued when stimulus is issued; an independent monitor decodes every
//   frame on the serial line and compares it against the queue head.
//   Frame length follows UART_TX_PARITY_EN (110 clocks with it, 100 without).
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_byte  = 8'h00;
  logic       wr_ready;
  logic [4:0] fifo_count;
  logic       tx_serial;
  logic       tx_active;
  logic       tx_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int frames_seen = 0;
  logic [7:0] sb[$];
  int starts[$];

  uart_tx_fifo #(
    .CLOCK_FREQUENCY(1_000_000),
    .BAUD_RATE      (100_000),
    .FIFO_DEPTH     (16)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_wr_valid  (wr_valid),
    .i_wr_byte   (wr_byte),
    .o_wr_ready  (wr_ready),
    .o_fifo_count(fifo_count),
    .o_tx_serial (tx_serial),
    .o_tx_active (tx_active),
    .o_tx_done   (tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Monitor: detects a start edge, samples mid-bit, and checks done/active
  // timing over the frame plus the idle cycle that follows it.
  initial begin : monitor
    logic       prev_line;
    logic [10:0] bits;
    logic       frame_ok;
    logic       aborted;
    logic [7:0] exp_b;
    int         t0;
    prev_line = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && prev_line === 1'b1 && tx_serial === 1'b0) begin
        t0 = cyc;
        aborted = 1'b0;
        frame_ok = 1'b1;
        bits = '0;
        for (int c = 0; c <= FRAME; c++) begin
          if (c > 0) @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          if (c < FRAME && (c % CPB) == CPB / 2) bits[c / CPB] = tx_serial;
          if (tx_done !== (c == FRAME - 1)) frame_ok = 1'b0;
          if (tx_active !== (c < FRAME)) frame_ok = 1'b0;
          if (c == FRAME && tx_serial !== 1'b1) frame_ok = 1'b0;
        end
        if (aborted) begin
          $display("frame starting at cycle %0d cut by reset", t0);
        end else begin
          frames_seen++;
          starts.push_back(t0);
          check("frame_expected", 32'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            exp_b = sb.pop_front();
            $display("frame at cycle %0d: byte 0x%02h (expect 0x%02h)", t0, bits[8:1], exp_b);
            check("frame_byte", 32'(bits[8:1]), 32'(exp_b));
            check("frame_start_stop", 32'({bits[0], bits[NBITS-1]}), 32'(2'b01));
            check("frame_done_active", 32'(frame_ok), 1);
`ifdef UART_TX_PARITY_EN
            check("frame_parity", 32'(bits[9]), 32'(^exp_b));
`endif
          end
        end
      end
      prev_line = tx_serial;
    end
  end

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || tx_active !== 1'b0 || fifo_count != 5'd0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain"}, 32'(n < budget), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic measure_frame(input string name);
    int n;
    int len;
    int dn;
    n = 0;
    len = 0;
    dn = 0;
    while (tx_active !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    while (tx_active === 1'b1 && len < 300) begin
      if (tx_done === 1'b1) dn++;
      @(negedge clk);
      len++;
    end
    check({name, "_len"}, len, FRAME);
    check({name, "_done_pulses"}, dn, 1);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int         acc;
    int         n;
    int         fb;
    logic [7:0] nxt;
    logic       rdy;

    // 1: reset state
    repeat (3) @(negedge clk);
    check("rst_serial", 32'(tx_serial), 1);
    check("rst_ready",  32'(wr_ready), 1);
    check("rst_count",  32'(fifo_count), 0);
    check("rst_active", 32'(tx_active), 0);
    check("rst_done",   32'(tx_done), 0);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);

    // 2: single byte and pop latency
    wr_byte  = 8'h65;
    wr_valid = 1'b1;
    sb.push_back(8'h65);
    @(negedge clk);
    wr_valid = 1'b0;
    check("lat_e0_line",  32'(tx_serial), 1);
    check("lat_e0_count", 32'(fifo_count), 1);
    @(negedge clk);
    check("lat_e1_line",   32'(tx_serial), 0);
    check("lat_e1_count",  32'(fifo_count), 0);
    check("lat_e1_active", 32'(tx_active), 1);
    wait_idle(400, "single");

    // 3: hold valid with 0x00.. from idle; 17 accepted, then full
    starts.delete();
    for (int i = 0; i <= 16; i++) sb.push_back(8'(i));
    nxt = 8'h00;
    acc = 0;
    wr_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      wr_byte = nxt;
      rdy = wr_ready;
      @(negedge clk);
      if (rdy) begin
        acc++;
        nxt = nxt + 8'h01;
      end
    end
    check("burst_accepted", acc, 17);
    check("burst_count",    32'(fifo_count), 16);
    check("burst_ready",    32'(wr_ready), 0);

    // 4: full with valid held; the pop cycle rejects, the next accepts
    wr_byte = 8'hAA;
    sb.push_back(8'hAA);
    n = 0;
    while (fifo_count == 5'd16 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("full_pop_count", 32'(fifo_count), 15);
    check("full_pop_ready", 32'(wr_ready), 1);
    @(negedge clk);
    wr_valid = 1'b0;
    check("full_refill_count", 32'(fifo_count), 16);
    check("full_refill_ready", 32'(wr_ready), 0);
    wait_idle(2500, "burst");
    check("b2b_frames", starts.size(), 18);
    for (int i = 1; i < starts.size(); i++) begin
      check("b2b_gap", starts[i] - starts[i-1], FRAME + 1);
    end

    // 5: reset in the middle of data bit 3 with 5 bytes queued
    wr_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_byte = 8'h30 + 8'(i);
      sb.push_back(wr_byte);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    check("mid_queued", 32'(fifo_count), 5);
    repeat (40) @(negedge clk);
    check("mid_active", 32'(tx_active), 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_serial", 32'(tx_serial), 1);
    check("mid_rst_count",  32'(fifo_count), 0);
    check("mid_rst_active", 32'(tx_active), 0);
    check("mid_rst_ready",  32'(wr_ready), 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    sb.delete();
    fb = frames_seen;
    repeat (300) @(negedge clk);
    check("post_rst_frames", frames_seen, fb);
    check("post_rst_line",   32'(tx_serial), 1);
    check("post_rst_count",  32'(fifo_count), 0);

    // 6: frame length (parity bit checked by the monitor when enabled)
    wr_byte  = 8'h65;
    wr_valid = 1'b1;
    sb.push_back(8'h65);
    @(negedge clk);
    wr_valid = 1'b0;
    measure_frame("len_65");
    wait_idle(400, "len_65");
    wr_byte  = 8'h07;
    wr_valid = 1'b1;
    sb.push_back(8'h07);
    @(negedge clk);
    wr_valid = 1'b0;
    measure_frame("len_07");
    wait_idle(400, "len_07");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
